// File: rtl/unsig_int_to_float.sv
// Unsigned 32-bit integer to IEEE-754 single-precision converter (fcvt.s.wu).
// Handshaked, multi-cycle: one normalisation shift per cycle, then round and pack.
module unsig_int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [2:0]  rm,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A     = 3'd0,
        NORMALISE = 3'd1,
        ROUND     = 3'd2,
        PACK      = 3'd3,
        PUT_Z     = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] m_r, m_s;
    logic [7:0]  e_r, e_s;
    logic [22:0] frac_r, frac_s;
    logic [2:0]  rm_r, rm_s;
    logic [31:0] z_r, z_s;
    logic        z_stb_r, z_stb_s;
    logic        a_ack_r, a_ack_s;
    logic        round_inc_s;
    logic [30:0] round_sum_s;

    // Rounding increment for a positive value: lsb, guard and sticky of the truncated significand.
    function automatic logic round_increment(input logic [2:0] mode, input logic lsb,
                                             input logic guard, input logic sticky);
        logic inc;
        case (mode)
            3'b001:  inc = 1'b0;
            3'b010:  inc = 1'b0;
            3'b011:  inc = guard | sticky;
            3'b100:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

    // Rounded {exponent, fraction}: a fraction carry-out ripples into the exponent,
    // which yields significand 0x800000 with the exponent bumped by one.
    always_comb begin
        round_inc_s = round_increment(rm_r, m_r[8], m_r[7], |m_r[6:0]);
        round_sum_s = {e_r, m_r[30:8]} + {30'd0, round_inc_s};
    end

    // Next-state and datapath update for the conversion FSM.
    always_comb begin
        state_s = state_r;
        m_s     = m_r;
        e_s     = e_r;
        frac_s  = frac_r;
        rm_s    = rm_r;
        z_s     = z_r;
        z_stb_s = z_stb_r;
        a_ack_s = a_ack_r;

        case (state_r)
            GET_A: begin
                if (a_ack_r && input_a_stb) begin
                    a_ack_s = 1'b0;
                    rm_s    = rm;
                    m_s     = input_a;
                    e_s     = 8'd158;
                    if (input_a == 32'd0) begin
                        z_s     = 32'h0000_0000;
                        z_stb_s = 1'b1;
                        state_s = PUT_Z;
                    end else if (input_a[31]) begin
                        // Already normalised: no shift cycle needed.
                        state_s = ROUND;
                    end else begin
                        state_s = NORMALISE;
                    end
                end else begin
                    a_ack_s = 1'b1;
                end
            end

            NORMALISE: begin
                if (m_r[31]) begin
                    state_s = ROUND;
                end else begin
                    m_s = {m_r[30:0], 1'b0};
                    e_s = e_r - 8'd1;
                    // Leave as soon as this shift brings a one into the MSB.
                    if (m_r[30]) begin
                        state_s = ROUND;
                    end else begin
                        state_s = NORMALISE;
                    end
                end
            end

            ROUND: begin
                e_s     = round_sum_s[30:23];
                frac_s  = round_sum_s[22:0];
                state_s = PACK;
            end

            PACK: begin
                z_s     = {1'b0, e_r, frac_r};
                z_stb_s = 1'b1;
                state_s = PUT_Z;
            end

            PUT_Z: begin
                if (output_z_ack) begin
                    z_stb_s = 1'b0;
                    a_ack_s = 1'b1;
                    state_s = GET_A;
                end else begin
                    z_stb_s = 1'b1;
                    state_s = PUT_Z;
                end
            end

            default: begin
                z_stb_s = 1'b0;
                a_ack_s = 1'b0;
                state_s = GET_A;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= GET_A;
            m_r     <= 32'd0;
            e_r     <= 8'd0;
            frac_r  <= 23'd0;
            rm_r    <= 3'd0;
            z_r     <= 32'h0000_0000;
            z_stb_r <= 1'b0;
            a_ack_r <= 1'b0;
        end else begin
            state_r <= state_s;
            m_r     <= m_s;
            e_r     <= e_s;
            frac_r  <= frac_s;
            rm_r    <= rm_s;
            z_r     <= z_s;
            z_stb_r <= z_stb_s;
            a_ack_r <= a_ack_s;
        end
    end

    assign input_a_ack  = a_ack_r;
    assign output_z     = z_r;
    assign output_z_stb = z_stb_r;

endmodule

// File: tb/tb_unsig_int_to_float.sv
// Directed self-checking bench for unsig_int_to_float, with an arithmetic reference
// model (remainder-versus-half rounding) and a per-cycle output compare process.
module tb_unsig_int_to_float;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic [2:0]  rm;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int          n_chk;
    int          n_fail;
    logic [31:0] cur_exp;
    logic [31:0] hold_exp;
    bit          chk_en;

    unsig_int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .rm           (rm),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference: locate the leading one, split kept bits and remainder, round by comparison.
    function automatic logic [31:0] model_z(input logic [31:0] a, input logic [2:0] r);
        int p;
        int ex;
        int sh;
        longint unsigned sig;
        longint unsigned rem;
        longint unsigned half;
        bit up;
        if (a == 32'd0) return 32'd0;
        p = 31;
        while (a[p] == 1'b0) p--;
        ex = 127 + p;
        if (p <= 23) begin
            sig  = longint'(a) << (23 - p);
            rem  = 64'd0;
            half = 64'd1;
        end else begin
            sh   = p - 23;
            sig  = longint'(a) >> sh;
            rem  = longint'(a) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
        end
        case (r)
            3'b001, 3'b010: up = 1'b0;
            3'b011:         up = (rem != 64'd0);
            3'b100:         up = (rem >= half);
            default:        up = (rem > half) || ((rem == half) && sig[0]);
        endcase
        if (up) sig = sig + 64'd1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            ex  = ex + 1;
        end
        return {1'b0, 8'(ex), sig[22:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] a);
        int lz;
        if (a == 32'd0) return 1;
        lz = 0;
        while (a[31 - lz] == 1'b0) lz++;
        return 3 + lz;
    endfunction

    // Output compare: while strobing, output_z must equal the model; otherwise it holds the last result.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            if (output_z_stb) chk("z_vs_model", output_z, cur_exp);
            else              chk("z_hold", output_z, hold_exp);
        end
    end

    // Tracks the last delivered result (cleared by reset).
    always @(posedge clk) begin
        if (!rst) hold_exp = 32'd0;
        else if (output_z_stb && output_z_ack) hold_exp = cur_exp;
    end

    task automatic convert(input logic [31:0] a, input logic [2:0] r, input logic [31:0] lit,
                           input int hold, input bit busy_stb);
        int lat;
        bit got;
        chk("model_pin", model_z(a, r), lit);
        cur_exp = model_z(a, r);
        @(negedge clk);
        input_a     = a;
        rm          = r;
        input_a_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (input_a_ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            timeout("ack_wait");
            input_a_stb = 1'b0;
            return;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) begin
                chk("ack_drop", {31'd0, input_a_ack}, 32'd0);
                if (busy_stb) begin
                    input_a = 32'hDEAD_BEEF;
                    rm      = 3'b011;
                end else begin
                    input_a_stb = 1'b0;
                end
            end
            if (output_z_stb) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            timeout("stb_wait");
            input_a_stb = 1'b0;
            return;
        end
        chk("latency", 32'(lat), 32'(model_lat(a)));
        chk("result_lit", output_z, lit);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_ack_low", {31'd0, input_a_ack}, 32'd0);
            chk("bp_stb_high", {31'd0, output_z_stb}, 32'd1);
        end
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        input_a_stb  = 1'b0;
        chk("stb_clear", {31'd0, output_z_stb}, 32'd0);
        chk("ack_back", {31'd0, input_a_ack}, 32'd1);
    endtask

    localparam int NV = 16;
    logic [31:0] v_a   [NV] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h0100_0001, 32'h0100_0001, 32'h0100_0001, 32'h0100_0003,
                                32'h0000_0000, 32'h8000_0000, 32'h0100_0001, 32'h0100_0001,
                                32'h1234_5678, 32'h00FF_FFFF, 32'h01FF_FFFF, 32'h01FF_FFFF};
    logic [2:0]  v_rm  [NV] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd0, 3'd4, 3'd3, 3'd0,
                                3'd0, 3'd0, 3'd2, 3'd7, 3'd0, 3'd3, 3'd1, 3'd0};
    logic [31:0] v_z   [NV] = '{32'h3F80_0000, 32'h4F80_0000, 32'h4F7F_FFFF, 32'h4F80_0000,
                                32'h4B80_0000, 32'h4B80_0001, 32'h4B80_0001, 32'h4B80_0002,
                                32'h0000_0000, 32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0000,
                                32'h4D91_A2B4, 32'h4B7F_FFFF, 32'h4BFF_FFFF, 32'h4C00_0000};
    int          v_hold[NV] = '{0, 1, 0, 0, 0, 2, 0, 0, 3, 0, 0, 0, 10, 0, 0, 1};

    initial begin
        bit got;
        n_chk        = 0;
        n_fail       = 0;
        chk_en       = 1'b0;
        cur_exp      = 32'd0;
        hold_exp     = 32'd0;
        rst          = 1'b0;
        input_a      = 32'd0;
        rm           = 3'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("rst_ack", {31'd0, input_a_ack}, 32'd0);
        chk("rst_z", output_z, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        chk("ack_after_rst", {31'd0, input_a_ack}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            convert(v_a[i], v_rm[i], v_z[i], v_hold[i], (i == 12));
        end

        // Reset and an operand offered in the same cycle: reset wins, nothing is captured.
        @(negedge clk);
        input_a     = 32'd0;
        input_a_stb = 1'b1;
        rst         = 1'b0;
        @(negedge clk);
        chk("prio_stb", {31'd0, output_z_stb}, 32'd0);
        chk("prio_ack", {31'd0, input_a_ack}, 32'd0);
        input_a_stb = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        chk("prio_ack_up", {31'd0, input_a_ack}, 32'd1);
        chk("prio_no_stb", {31'd0, output_z_stb}, 32'd0);

        // Abort a long conversion with reset part-way through normalisation.
        input_a     = 32'h0000_0001;
        rm          = 3'd0;
        input_a_stb = 1'b1;
        cur_exp     = 32'h3F80_0000;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (input_a_ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) timeout("abort_ack_wait");
        @(negedge clk);
        input_a_stb = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy", {31'd0, output_z_stb}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("abort_rst_ack", {31'd0, input_a_ack}, 32'd0);
        chk("abort_rst_z", output_z, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_no_stb", {31'd0, output_z_stb}, 32'd0);
            if (i == 0) chk("abort_ack_up", {31'd0, input_a_ack}, 32'd1);
        end
        convert(32'h0000_0002, 3'd0, 32'h4000_0000, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unsig_int_to_float.md
UNSIG_INT_TO_FLOAT -- requirements
Module: unsig_int_to_float

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port input_a, input, 32, unsigned integer operand (fcvt.s.wu source).
REQ-004 SHALL have port rm, input, 3, rounding mode, sampled with input_a.
REQ-005 SHALL have port input_a_stb, input, 1, operand valid.
REQ-006 SHALL have port input_a_ack, output, 1, ready to accept operand.
REQ-007 SHALL have port output_z, output, 32, IEEE-754 single-precision result.
REQ-008 SHALL have port output_z_stb, output, 1, result valid.
REQ-009 SHALL have port output_z_ack, input, 1, consumer accepts result.

Function
REQ-010 SHALL use FSM states GET_A, NORMALISE, ROUND, PACK, PUT_Z.
REQ-011 GET_A: input_a_ack=1; operand and rm captured on the cycle input_a_stb & input_a_ack are both 1; input_a_ack SHALL drop the following cycle.
REQ-012 On capture: input_a==0 -> z=0x00000000, go to PUT_Z; else mantissa register m[31:0]=input_a, exponent e=158 (127+31), go to NORMALISE.
REQ-013 NORMALISE: while m[31]==0 shift m left 1 and decrement e, one bit per cycle; when m[31]==1 go to ROUND.
REQ-014 ROUND: significand = m[31:8], guard g = m[7], sticky s = |m[6:0].
REQ-015 Rounding increment: rm=000 (RNE) g & (s | m[8]); rm=001 (RTZ) 0; rm=010 (RDN) 0; rm=011 (RUP) g | s; rm=100 (RMM) g; rm=101..111 SHALL behave as RNE.
REQ-016 Significand increment carry-out (0xFFFFFF+1) SHALL set significand to 0x800000 and increment e.
REQ-017 PACK: z = {1'b0, e[7:0], significand[22:0]}; sign always 0; no overflow/NaN/Inf possible; go to PUT_Z.
REQ-018 PUT_Z: output_z_stb=1, output_z=z held stable until output_z_ack==1; on that cycle output_z_stb SHALL clear the next cycle and FSM returns to GET_A.
REQ-019 Latency from capture to output_z_stb: zero operand 1 cycle; otherwise 3 + (number of leading zeros of input_a) cycles (max 34).
REQ-020 input_a_stb asserted while not in GET_A SHALL be ignored (not acked).
REQ-021 output_z SHALL retain last delivered value after handshake until next PUT_Z.

Reset
REQ-022 rst==0 at a clock edge SHALL force state GET_A, output_z_stb=0, input_a_ack=0 (ack rises the cycle after rst releases), output_z=0x00000000.
REQ-023 Reset asserted mid-operation (NORMALISE/ROUND/PACK/PUT_Z) SHALL abort the conversion with no output strobe produced.
REQ-024 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-025 input_a=0x00000001, rm=000 -> output_z=0x3F800000 after 34 cycles of latency.
REQ-026 input_a=0xFFFFFFFF: rm=000 -> 0x4F800000; rm=001 -> 0x4F7FFFFF; rm=011 -> 0x4F800000.
REQ-027 Tie cases: 0x01000001 rm=000 -> 0x4B800000, rm=100 -> 0x4B800001, rm=011 -> 0x4B800001; 0x01000003 rm=000 -> 0x4B800002.
REQ-028 input_a=0x00000000 -> output_z=0x00000000, output_z_stb one cycle after capture; 0x80000000 -> 0x4F000000.
REQ-029 Backpressure: hold output_z_ack=0 for 10 cycles -> output_z_stb and output_z stable, input_a_ack=0 throughout; ack -> stb low next cycle, input_a_ack high.
REQ-030 Assert rst=0 during NORMALISE of 0x00000001 -> no output_z_stb; after release, next conversion of 0x00000002 -> 0x40000000.
